// File: rtl/serial_paralelo_rx.sv
// Single-lane serial-to-parallel receiver: comma-based byte alignment,
// link activation after SYNC_COUNT aligned commas, {valid, data} word rebuild.
module serial_paralelo_rx #(
   parameter int              WIDTH      = 8,
   parameter logic [WIDTH-1:0] COMMA     = 8'hBC,
   parameter int              SYNC_COUNT = 4
) (
   input  logic             clk16f,
   input  logic             reset,
   input  logic             serial,
   output logic [WIDTH:0]   paralelo_out,
   output logic             word_strobe,
   output logic             active
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int NW = (SYNC_COUNT > 0) ? $clog2(SYNC_COUNT + 1) : 1;
   localparam logic [CW-1:0] LAST_BIT  = CW'(WIDTH - 1);
   localparam logic [NW-1:0] SYNC_LAST = NW'(SYNC_COUNT);

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      ALIGN  = 2'd1,
      ACTIVE = 2'd2
   } state_t;

   state_t              state_r, state_nx;
   // Only the last WIDTH-1 bits are kept; the oldest one is never needed.
   logic [WIDTH-2:0]    sr_r;
   logic [CW-1:0]       bit_cnt_r, bit_cnt_nx;
   logic [NW-1:0]       comma_cnt_r, comma_cnt_nx;
   logic [NW-1:0]       comma_inc_s;
   logic [WIDTH-1:0]    cand_s;
   logic                boundary_s;
   logic                is_comma_s;
   logic                strobe_s;

   function automatic logic [WIDTH:0] decode_word(input logic [WIDTH-1:0] w);
      if (w == COMMA) begin
         decode_word = {1'b0, COMMA};
      end else begin
         decode_word = {1'b1, w};
      end
   endfunction

   assign cand_s      = {sr_r, serial};
   assign boundary_s  = (bit_cnt_r == LAST_BIT);
   assign is_comma_s  = (cand_s == COMMA);
   assign comma_inc_s = comma_cnt_r + NW'(1);

   // Next-state, alignment counters and word strobe decision
   always_comb begin
      state_nx     = state_r;
      bit_cnt_nx   = bit_cnt_r;
      comma_cnt_nx = comma_cnt_r;
      strobe_s     = 1'b0;
      case (state_r)
         HUNT: begin
            bit_cnt_nx = '0;
            if (is_comma_s) begin
               state_nx     = ALIGN;
               comma_cnt_nx = NW'(1);
            end else begin
               state_nx     = HUNT;
               comma_cnt_nx = '0;
            end
         end
         ALIGN: begin
            if (boundary_s) begin
               bit_cnt_nx = '0;
               if (!is_comma_s) begin
                  state_nx     = HUNT;
                  comma_cnt_nx = '0;
               end else if (comma_inc_s == SYNC_LAST) begin
                  state_nx     = ACTIVE;
                  comma_cnt_nx = '0;
               end else begin
                  comma_cnt_nx = comma_inc_s;
               end
            end else begin
               bit_cnt_nx = bit_cnt_r + CW'(1);
            end
         end
         ACTIVE: begin
            if (boundary_s) begin
               bit_cnt_nx = '0;
               strobe_s   = 1'b1;
            end else begin
               bit_cnt_nx = bit_cnt_r + CW'(1);
            end
         end
         default: begin
            state_nx     = HUNT;
            bit_cnt_nx   = '0;
            comma_cnt_nx = '0;
         end
      endcase
   end

   // State, shift history and registered outputs
   always_ff @(posedge clk16f or posedge reset) begin
      if (reset) begin
         state_r      <= HUNT;
         sr_r         <= '0;
         bit_cnt_r    <= '0;
         comma_cnt_r  <= '0;
         paralelo_out <= '0;
         word_strobe  <= 1'b0;
         active       <= 1'b0;
      end else begin
         state_r      <= state_nx;
         sr_r         <= cand_s[WIDTH-2:0];
         bit_cnt_r    <= bit_cnt_nx;
         comma_cnt_r  <= comma_cnt_nx;
         word_strobe  <= strobe_s;
         active       <= (state_nx == ACTIVE);
         if (strobe_s) begin
            paralelo_out <= decode_word(cand_s);
         end
      end
   end

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// Directed bench for serial_paralelo_rx: reset, acquisition, decode,
// failed sync, mid-word reset and straddling comma.
module tb_serial_paralelo_rx;

   logic       clk16f = 1'b0;
   logic       reset  = 1'b1;
   logic       serial = 1'b0;
   logic [8:0] paralelo_out;
   logic       word_strobe;
   logic       active;

   int checks     = 0;
   int errors     = 0;
   int strobe_cnt = 0;
   logic act_seen = 1'b0;

   serial_paralelo_rx dut (
      .clk16f       (clk16f),
      .reset        (reset),
      .serial       (serial),
      .paralelo_out (paralelo_out),
      .word_strobe  (word_strobe),
      .active       (active)
   );

   always #5 clk16f = ~clk16f;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      serial = b;
      @(posedge clk16f);
      #1;
      if (word_strobe === 1'b1) strobe_cnt++;
      if (active === 1'b1) act_seen = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] v);
      for (int i = 7; i >= 0; i--) send_bit(v[i]);
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      @(posedge clk16f);
      #1;
      reset = 1'b0;
   endtask

   task automatic expect_word(input string tag, input logic [7:0] v, input logic [8:0] exp);
      strobe_cnt = 0;
      send_byte(v);
      check({tag, "_strobe_now"}, word_strobe, 1'b1);
      check({tag, "_strobe_cnt"}, strobe_cnt, 1);
      check({tag, "_word"}, paralelo_out, exp);
   endtask

   initial begin
      logic [7:0] comma;
      comma = 8'hBC;

      // 1. reset state, then idle zeros
      #2;
      check("rst_out", paralelo_out, 9'h000);
      check("rst_strobe", word_strobe, 1'b0);
      check("rst_active", active, 1'b0);
      @(posedge clk16f);
      #1;
      reset = 1'b0;
      strobe_cnt = 0;
      act_seen   = 1'b0;
      for (int i = 0; i < 16; i++) send_bit(1'b0);
      check("idle_active", act_seen, 1'b0);
      check("idle_strobes", strobe_cnt, 0);

      // 2. acquisition after a 101 prefix
      strobe_cnt = 0;
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      for (int k = 0; k < 32; k++) begin
         send_bit(comma[7 - (k % 8)]);
         check("acq_active", active, (k == 31));
      end
      check("acq_strobes", strobe_cnt, 0);

      // 3. data decode with 8-cycle strobe period
      expect_word("d_ff", 8'hFF, 9'h1FF);
      expect_word("d_bc", 8'hBC, 9'h0BC);
      expect_word("d_55", 8'h55, 9'h155);
      send_bit(1'b0);
      check("hold_strobe", word_strobe, 1'b0);
      check("hold_word", paralelo_out, 9'h155);
      for (int i = 0; i < 7; i++) send_bit(1'b0);
      check("d_00_word", paralelo_out, 9'h100);

      // 4. failed sync, then good sync
      pulse_reset();
      check("fs_reset_active", active, 1'b0);
      act_seen   = 1'b0;
      strobe_cnt = 0;
      for (int i = 0; i < 3; i++) send_byte(8'hBC);
      send_byte(8'h55);
      check("fs_no_active", act_seen, 1'b0);
      for (int i = 0; i < 3; i++) send_byte(8'hBC);
      check("fs_3_commas", act_seen, 1'b0);
      send_byte(8'hBC);
      check("fs_active", active, 1'b1);
      check("fs_strobes", strobe_cnt, 0);
      expect_word("d_a5", 8'hA5, 9'h1A5);

      // 5. mid-word reset after 3 bits of 0xFA
      send_bit(1'b1);
      send_bit(1'b1);
      send_bit(1'b1);
      reset = 1'b1;
      #1;
      check("mw_active", active, 1'b0);
      check("mw_word", paralelo_out, 9'h000);
      check("mw_strobe", word_strobe, 1'b0);
      @(posedge clk16f);
      #1;
      reset = 1'b0;
      strobe_cnt = 0;
      act_seen   = 1'b0;
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      check("mw_partial_strobes", strobe_cnt, 0);
      for (int i = 0; i < 3; i++) send_byte(8'hBC);
      check("mw_3_commas", act_seen, 1'b0);
      send_byte(8'hBC);
      check("mw_reacq", active, 1'b1);
      check("mw_strobes", strobe_cnt, 0);
      expect_word("d_3c", 8'h3C, 9'h13C);

      // 6. comma straddling a word boundary is plain data
      expect_word("fc_0b", 8'h0B, 9'h10B);
      expect_word("fc_c0", 8'hC0, 9'h1C0);
      check("fc_active", active, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
